pattern_blinker: RTL and testbench

PATTERN_BLINKER -- requirements
Module: pattern_blinker

---
 rtl/blinker_pkg.sv | 10 +
 rtl/blink_timebase.sv | 36 +++
 rtl/pattern_blinker.sv | 48 ++++
 tb/tb_pattern_blinker.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/blinker_pkg.sv
// blinker_pkg: mode encodings and step width shared by the pattern blinker
package blinker_pkg;
  localparam int STEP_WIDTH = 3;
  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STEADY = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;
endpackage

// File: rtl/blink_timebase.sv
// blink_timebase: shared half-period counter, 3-bit step and step tick
module blink_timebase
  import blinker_pkg::*;
#(
  parameter int CNT_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CNT_WIDTH-1:0]  half_period,
  input  logic                  sync,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  step_tick
);
  logic [CNT_WIDTH-1:0] cnt, last;
  logic terminal;
  // >= rather than == so lowering half_period mid-count wraps immediately
  assign last = (half_period == '0) ? '0 : half_period - CNT_WIDTH'(1);
  assign terminal = cnt >= last;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt       <= '0;
      step      <= '0;
      step_tick <= 1'b0;
    end else if (sync) begin
      cnt       <= '0;
      step      <= '0;
      step_tick <= 1'b0;
    end else if (terminal) begin
      cnt       <= '0;
      step      <= step + STEP_WIDTH'(1);
      step_tick <= 1'b1;
    end else begin
      cnt       <= cnt + CNT_WIDTH'(1);
      step_tick <= 1'b0;
    end
endmodule

// File: rtl/pattern_blinker.sv
// pattern_blinker: per-channel lamp drivers (off/steady/blink/toggle) on a shared timebase
module pattern_blinker
  import blinker_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   enable,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CNT_WIDTH-1:0]  half_period,
  input  logic                  sync,
  output logic [CHANNELS-1:0]   out,
  output logic                  step_tick
);
  logic [STEP_WIDTH-1:0] step;
  logic even;
  blink_timebase #(.CNT_WIDTH(CNT_WIDTH)) u_timebase (
    .clk(clk),
    .reset_n(reset_n),
    .half_period(half_period),
    .sync(sync),
    .step(step),
    .step_tick(step_tick)
  );
  assign even = (step & STEP_WIDTH'(1)) == '0;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mode_e md;
    logic tog, tog_next, out_next, out_q;
    // toggle holds while disabled and is cleared whenever the channel leaves TOGGLE
    always_comb begin
      md       = mode_e'(mode[2*g +: 2]);
      tog_next = (md == MODE_TOGGLE) && (enable[g] ? ~tog : tog);
      out_next = (md == MODE_TOGGLE) ? tog_next
               : enable[g] && (md == MODE_STEADY || (md == MODE_BLINK && even));
    end
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        tog   <= 1'b0;
        out_q <= 1'b0;
      end else begin
        tog   <= tog_next;
        out_q <= out_next;
      end
    assign out[g] = out_q;
  end
endmodule

// File: tb/tb_pattern_blinker.sv
// tb_pattern_blinker: directed and randomized checks of pattern_blinker against a cycle model
module tb_pattern_blinker;
  localparam int CH = 4;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sync = 1'b0;
  logic [CH-1:0] enable = '0;
  logic [2*CH-1:0] mode = '0;
  logic [CW-1:0] half_period = '0;
  logic [CH-1:0] out;
  logic step_tick;
  int checks = 0;
  int errors = 0;
  int m_cnt, m_step;
  bit m_tick;
  bit [CH-1:0] m_out, m_tog;

  always #5 clk = ~clk;

  pattern_blinker #(.CHANNELS(CH), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .mode(mode),
    .half_period(half_period),
    .sync(sync),
    .out(out),
    .step_tick(step_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_step = 0;
    m_tick = 0;
    m_out = '0;
    m_tog = '0;
  endtask

  // lamp i is lit by mode value md: 0 off, 1 steady, 2 lit on even steps, 3 flips each enabled clock
  task automatic model_edge();
    int h, md;
    bit even;
    h = (half_period == 0) ? 1 : int'(half_period);
    even = (m_step % 2) == 0;
    if (sync) begin
      m_cnt = 0;
      m_step = 0;
      m_tick = 0;
    end else if (m_cnt >= h - 1) begin
      m_cnt = 0;
      m_step = (m_step + 1) % 8;
      m_tick = 1;
    end else begin
      m_cnt++;
      m_tick = 0;
    end
    for (int i = 0; i < CH; i++) begin
      md = int'(mode[2*i +: 2]);
      if (md == 3) begin
        if (enable[i]) m_tog[i] = ~m_tog[i];
        m_out[i] = m_tog[i];
      end else begin
        m_tog[i] = 0;
        m_out[i] = enable[i] && (md == 1 || (md == 2 && even));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check("out", out, m_out);
    check("tick", step_tick, m_tick);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    enable = '1;
    mode = 8'h55;
    half_period = 4;
    repeat (3) begin
      cycle();
      check("rst_out", out, 0);
    end
    reset_n = 1'b1;
    cycle();
    check("release_out", out, 4'hF);

    mode = 8'h56;
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      check("blink_hp4", out[0], ((k - 1) / 4) % 2 == 0);
      check("tick_hp4", step_tick, k % 4 == 0);
    end

    half_period = 0;
    cycle();
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check("tick_hp0", step_tick, 1);
    end

    half_period = 4;
    mode = 8'h5E;
    for (int k = 0; k < 8; k++) begin
      enable = (k < 3) ? 4'b1111 : 4'b1101;
      cycle();
      check("toggle_seq", out[1], (k < 3) ? (k % 2 == 0) : 1);
    end

    half_period = 10;
    mode = 8'h56;
    enable = '1;
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    repeat (2) cycle();
    sync = 1'b1;
    cycle();
    check("sync_no_tick", step_tick, 0);
    sync = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check("tick_after_sync", step_tick, k == 10);
    end

    half_period = 100;
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    repeat (50) cycle();
    half_period = 5;
    cycle();
    check("lower_hp_tick", step_tick, 1);
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check("tick_hp5", step_tick, k % 5 == 0);
    end

    for (int n = 0; n < 400; n++) begin
      enable = CH'($urandom);
      mode = (2*CH)'($urandom);
      half_period = CW'($urandom_range(0, 6));
      sync = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 40) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_out", out, 0);
        check("async_rst_tick", step_tick, 0);
        reset_n = 1'b1;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
